div_ctrl: RTL and testbench

Multi-cycle sequencer for the EX-stage divider, issuing DIV/DIVU as 32 radix-2 restoring steps. It raises the EX stall request to the pipeline control unit until the result is ready. The result is {remainder, quotient}, which EX places on its HI/LO bus. It sits beside EX and is fed by EX's decoded operands; flush and annul come from the control unit.

---
 rtl/div_ctrl.sv | 155 +++++++++++++++
 tb/tb_div_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/div_ctrl.sv
// rtl/div_ctrl.sv - radix-2 restoring DIV/DIVU sequencer with EX stall request
// One quotient bit per cycle; signs are stripped on entry and reapplied on the final step.
module div_ctrl #(
   parameter int WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 div_start,
   input  logic                 div_signed,
   input  logic [WIDTH-1:0]     div_opdata1,
   input  logic [WIDTH-1:0]     div_opdata2,
   input  logic                 div_annul,
   output logic                 div_ready,
   output logic [2*WIDTH-1:0]   div_result,
   output logic                 stallreq_for_div
);

   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {
      S_FREE   = 2'd0,
      S_BYZERO = 2'd1,
      S_ON     = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   state_t               state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [WIDTH-1:0]     rem_q, rem_d;
   logic [WIDTH-1:0]     quo_q, quo_d;
   logic [WIDTH-1:0]     dvs_q, dvs_d;
   logic                 neg_quo_q, neg_quo_d;
   logic                 neg_rem_q, neg_rem_d;
   logic                 ready_q, ready_d;
   logic [2*WIDTH-1:0]   result_q, result_d;

   logic [WIDTH:0]       shifted;
   logic                 no_borrow;
   logic [WIDTH-1:0]     step_rem;
   logic [WIDTH-1:0]     step_quo;
   logic [WIDTH-1:0]     abs1;
   logic [WIDTH-1:0]     abs2;
   logic                 op1_neg;
   logic                 op2_neg;

   // quo_q starts as the dividend magnitude and fills with quotient bits from the LSB
   always_comb begin
      shifted   = {rem_q, quo_q[WIDTH-1]};
      no_borrow = (shifted >= {1'b0, dvs_q});
      step_rem  = no_borrow ? (shifted[WIDTH-1:0] - dvs_q) : shifted[WIDTH-1:0];
      step_quo  = {quo_q[WIDTH-2:0], no_borrow};

      op1_neg = div_signed & div_opdata1[WIDTH-1];
      op2_neg = div_signed & div_opdata2[WIDTH-1];
      abs1    = op1_neg ? (~div_opdata1 + 1'b1) : div_opdata1;
      abs2    = op2_neg ? (~div_opdata2 + 1'b1) : div_opdata2;
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      rem_d     = rem_q;
      quo_d     = quo_q;
      dvs_d     = dvs_q;
      neg_quo_d = neg_quo_q;
      neg_rem_d = neg_rem_q;
      ready_d   = ready_q;
      result_d  = result_q;

      case (state_q)
         S_FREE: begin
            ready_d = 1'b0;
            if (div_start && !div_annul) begin
               if (div_opdata2 == '0) begin
                  state_d = S_BYZERO;
               end else begin
                  state_d   = S_ON;
                  cnt_d     = '0;
                  rem_d     = '0;
                  quo_d     = abs1;
                  dvs_d     = abs2;
                  neg_quo_d = op1_neg ^ op2_neg;
                  neg_rem_d = op1_neg;
               end
            end
         end
         S_ON: begin
            if (div_annul || !div_start) begin
               state_d = S_FREE;
               ready_d = 1'b0;
            end else begin
               rem_d = step_rem;
               quo_d = step_quo;
               cnt_d = cnt_q + CW'(1);
               if (cnt_q == CW'(WIDTH - 1)) begin
                  state_d  = S_DONE;
                  ready_d  = 1'b1;
                  result_d = {neg_rem_q ? (~step_rem + 1'b1) : step_rem,
                              neg_quo_q ? (~step_quo + 1'b1) : step_quo};
               end
            end
         end
         S_BYZERO: begin
            if (div_annul) begin
               state_d = S_FREE;
               ready_d = 1'b0;
            end else begin
               state_d  = S_DONE;
               ready_d  = 1'b1;
               result_d = '0;
            end
         end
         S_DONE: begin
            // result is deliberately left in place after the handshake completes
            if (div_annul || !div_start) begin
               state_d = S_FREE;
               ready_d = 1'b0;
            end
         end
         default: begin
            state_d = S_FREE;
            ready_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_FREE;
         cnt_q     <= '0;
         rem_q     <= '0;
         quo_q     <= '0;
         dvs_q     <= '0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         ready_q   <= 1'b0;
         result_q  <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rem_q     <= rem_d;
         quo_q     <= quo_d;
         dvs_q     <= dvs_d;
         neg_quo_q <= neg_quo_d;
         neg_rem_q <= neg_rem_d;
         ready_q   <= ready_d;
         result_q  <= result_d;
      end
   end

   assign div_ready        = ready_q;
   assign div_result       = result_q;
   assign stallreq_for_div = div_start & ~ready_q & ~div_annul & ~rst;

endmodule

// File: tb/tb_div_ctrl.sv
// tb/tb_div_ctrl.sv - directed self-checking bench for div_ctrl
module tb_div_ctrl;

   logic        clk;
   logic        rst;
   logic        div_start;
   logic        div_signed;
   logic [31:0] div_opdata1;
   logic [31:0] div_opdata2;
   logic        div_annul;
   logic        div_ready;
   logic [63:0] div_result;
   logic        stallreq_for_div;

   int vec_cnt;
   int err_cnt;

   div_ctrl #(.WIDTH(32)) dut (
      .clk              (clk),
      .rst              (rst),
      .div_start        (div_start),
      .div_signed       (div_signed),
      .div_opdata1      (div_opdata1),
      .div_opdata2      (div_opdata2),
      .div_annul        (div_annul),
      .div_ready        (div_ready),
      .div_result       (div_result),
      .stallreq_for_div (stallreq_for_div)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Starts an op in the current (FREE) cycle and runs until ready or limit; no checking here.
   task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                        output int rdy_cyc, output int stall_n, output int stall_last);
      div_opdata1 = a;
      div_opdata2 = b;
      div_signed  = s;
      div_annul   = 1'b0;
      div_start   = 1'b1;
      rdy_cyc     = -1;
      stall_n     = 0;
      stall_last  = -1;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (stallreq_for_div) begin
            stall_n++;
            stall_last = c;
         end
         if (div_ready) begin
            rdy_cyc = c;
            break;
         end
         next_cycle();
      end
   endtask

   task automatic drop_start();
      div_start = 1'b0;
      next_cycle();
   endtask

   task automatic test_reset();
      rst = 1'b1; div_start = 1'b1; div_signed = 1'b0; div_annul = 1'b0;
      div_opdata1 = 32'd10; div_opdata2 = 32'd5;
      for (int c = 0; c < 2; c++) begin
         next_cycle();
         @(negedge clk);
         vec_cnt++;
         if (div_ready !== 1'b0 || div_result !== 64'd0 || stallreq_for_div !== 1'b0) begin
            err_cnt++;
            $display("FAIL reset_state: ready=%b result=%h stall=%b, want 0/0/0",
                     div_ready, div_result, stallreq_for_div);
         end
      end
      next_cycle();
      rst = 1'b0;
      div_start = 1'b0;
      next_cycle();
   endtask

   task automatic test_unsigned();
      int r, sn, sl;
      do_op(32'd100, 32'd7, 1'b0, r, sn, sl);
      vec_cnt++;
      if (r !== 33) begin err_cnt++; $display("FAIL divu_latency: got %0d want 33", r); end
      vec_cnt++;
      if (div_result !== {32'h2, 32'hE}) begin
         err_cnt++; $display("FAIL divu_100_7: got %h want %h", div_result, {32'h2, 32'hE});
      end
      vec_cnt++;
      if (sn !== 33 || sl !== 32) begin
         err_cnt++; $display("FAIL divu_stall: count=%0d last=%0d want 33/32", sn, sl);
      end
      drop_start();
      do_op(32'hFFFFFFF9, 32'd2, 1'b0, r, sn, sl);
      vec_cnt++;
      if (r !== 33 || div_result !== {32'h1, 32'h7FFFFFFC}) begin
         err_cnt++; $display("FAIL divu_big: cyc=%0d got %h want 33 %h", r, div_result, {32'h1, 32'h7FFFFFFC});
      end
      drop_start();
   endtask

   task automatic test_signed();
      int r, sn, sl;
      do_op(32'hFFFFFFF9, 32'd2, 1'b1, r, sn, sl);
      vec_cnt++;
      if (r !== 33 || div_result !== {32'hFFFFFFFF, 32'hFFFFFFFD}) begin
         err_cnt++; $display("FAIL div_m7_2: cyc=%0d got %h want 33 %h", r, div_result, {32'hFFFFFFFF, 32'hFFFFFFFD});
      end
      drop_start();
      do_op(32'd7, 32'hFFFFFFFE, 1'b1, r, sn, sl);
      vec_cnt++;
      if (r !== 33 || div_result !== {32'h1, 32'hFFFFFFFD}) begin
         err_cnt++; $display("FAIL div_7_m2: cyc=%0d got %h want 33 %h", r, div_result, {32'h1, 32'hFFFFFFFD});
      end
      drop_start();
   endtask

   task automatic test_byzero();
      int r, sn, sl;
      do_op(32'd5, 32'd0, 1'b0, r, sn, sl);
      vec_cnt++;
      if (r !== 2) begin err_cnt++; $display("FAIL byzero_latency: got %0d want 2", r); end
      vec_cnt++;
      if (div_result !== 64'd0) begin
         err_cnt++; $display("FAIL byzero_result: got %h want 0", div_result);
      end
      vec_cnt++;
      if (sn !== 2 || sl !== 1) begin
         err_cnt++; $display("FAIL byzero_stall: count=%0d last=%0d want 2/1", sn, sl);
      end
      drop_start();
   endtask

   task automatic test_annul();
      int r, sn, sl;
      div_opdata1 = 32'd100; div_opdata2 = 32'd7; div_signed = 1'b0;
      div_annul = 1'b0; div_start = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         vec_cnt++;
         if (div_ready !== 1'b0) begin
            err_cnt++; $display("FAIL annul_pre_ready: cycle %0d ready=%b want 0", c, div_ready);
         end
         next_cycle();
      end
      div_annul = 1'b1;
      @(negedge clk);
      vec_cnt++;
      if (stallreq_for_div !== 1'b0 || div_ready !== 1'b0) begin
         err_cnt++; $display("FAIL annul_stall: stall=%b ready=%b want 0/0", stallreq_for_div, div_ready);
      end
      next_cycle();
      do_op(32'd9, 32'd3, 1'b0, r, sn, sl);
      vec_cnt++;
      if (r !== 33 || div_result !== {32'h0, 32'h3}) begin
         err_cnt++; $display("FAIL annul_restart: cyc=%0d got %h want 33 %h", r, div_result, {32'h0, 32'h3});
      end
      drop_start();
   endtask

   task automatic test_overflow_reset();
      int r, sn, sl;
      do_op(32'h80000000, 32'hFFFFFFFF, 1'b1, r, sn, sl);
      vec_cnt++;
      if (r !== 33 || div_result !== {32'h0, 32'h80000000}) begin
         err_cnt++; $display("FAIL div_overflow: cyc=%0d got %h want 33 %h", r, div_result, {32'h0, 32'h80000000});
      end
      drop_start();
      div_opdata1 = 32'd100; div_opdata2 = 32'd7; div_signed = 1'b0; div_start = 1'b1;
      for (int c = 0; c < 15; c++) next_cycle();
      rst = 1'b1;
      @(negedge clk);
      vec_cnt++;
      if (stallreq_for_div !== 1'b0) begin
         err_cnt++; $display("FAIL rst_stall: got %b want 0", stallreq_for_div);
      end
      next_cycle();
      rst = 1'b0;
      div_start = 1'b0;
      @(negedge clk);
      vec_cnt++;
      if (div_ready !== 1'b0 || div_result !== 64'd0 || stallreq_for_div !== 1'b0) begin
         err_cnt++; $display("FAIL rst_mid_op: ready=%b result=%h stall=%b want 0/0/0",
                             div_ready, div_result, stallreq_for_div);
      end
      next_cycle();
      do_op(32'd100, 32'd7, 1'b0, r, sn, sl);
      vec_cnt++;
      if (r !== 33 || div_result !== {32'h2, 32'hE}) begin
         err_cnt++; $display("FAIL rst_then_op: cyc=%0d got %h want 33 %h", r, div_result, {32'h2, 32'hE});
      end
      drop_start();
   endtask

   task automatic test_back_to_back();
      int r, sn, sl;
      do_op(32'd9, 32'd3, 1'b0, r, sn, sl);
      vec_cnt++;
      if (r !== 33) begin err_cnt++; $display("FAIL hs_latency: got %0d want 33", r); end
      for (int k = 0; k < 3; k++) begin
         next_cycle();
         div_opdata1 = 32'd1000 + k;
         div_opdata2 = 32'd1;
         @(negedge clk);
         vec_cnt++;
         if (div_ready !== 1'b1 || div_result !== {32'h0, 32'h3}) begin
            err_cnt++; $display("FAIL hs_hold_%0d: ready=%b result=%h want 1 %h", k, div_ready, div_result, {32'h0, 32'h3});
         end
      end
      next_cycle();
      div_start = 1'b0;
      @(negedge clk);
      vec_cnt++;
      if (div_ready !== 1'b1) begin
         err_cnt++; $display("FAIL hs_drop_same_cycle: ready=%b want 1", div_ready);
      end
      next_cycle();
      vec_cnt++;
      if (div_ready !== 1'b0 || div_result !== {32'h0, 32'h3}) begin
         err_cnt++; $display("FAIL hs_after_drop: ready=%b result=%h want 0 %h", div_ready, div_result, {32'h0, 32'h3});
      end
      do_op(32'd1000, 32'd10, 1'b0, r, sn, sl);
      vec_cnt++;
      if (r !== 33 || sn !== 33 || div_result !== {32'h0, 32'd100}) begin
         err_cnt++; $display("FAIL b2b_op: cyc=%0d stall=%0d got %h want 33/33 %h", r, sn, div_result, {32'h0, 32'd100});
      end
      drop_start();
   endtask

   initial begin
      vec_cnt = 0;
      err_cnt = 0;
      test_reset();
      test_unsigned();
      test_signed();
      test_byzero();
      test_annul();
      test_overflow_reset();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
